// File: rtl/pe_operand_fetch_if.sv
// pe_operand_fetch_if
//   Bundles the configuration, neighbour, ALU and result-channel signals of
//   the CGRA PE operand-fetch stage.
//   slave  : modport used by pe_operand_fetch.
//   master : modport for the surrounding PE / environment.
//   Signals:
//     cfg_we, cfg_instr        instruction load strobe and word
//     nb_data/nb_valid/nb_ready four neighbour channels, slice k = {W,S,E,N}
//     alu_in1/alu_in2/alu_en/alu_op/alu_out  ALU drive and combinational result
//     out_data/out_valid/out_ready           result channel
//     op_err                   sticky unsupported-op flag
//     stall_cnt                only with PE_FETCH_STALL_CNT_EN defined
interface pe_operand_fetch_if #(
  parameter int WIDTH = 32
);
  logic               cfg_we;
  logic [31:0]        cfg_instr;
  logic [4*WIDTH-1:0] nb_data;
  logic [3:0]         nb_valid;
  logic [3:0]         nb_ready;
  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic               alu_en;
  logic [3:0]         alu_op;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               op_err;
`ifdef PE_FETCH_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  modport slave (
`ifdef PE_FETCH_STALL_CNT_EN
    output stall_cnt,
`endif
    input  cfg_we, cfg_instr, nb_data, nb_valid, alu_out, out_ready,
    output nb_ready, alu_in1, alu_in2, alu_en, alu_op, out_data, out_valid, op_err
  );

  modport master (
`ifdef PE_FETCH_STALL_CNT_EN
    input  stall_cnt,
`endif
    output cfg_we, cfg_instr, nb_data, nb_valid, alu_out, out_ready,
    input  nb_ready, alu_in1, alu_in2, alu_en, alu_op, out_data, out_valid, op_err
  );
endinterface

// File: rtl/pe_operand_fetch.sv
// pe_operand_fetch
//   Operand-fetch stage in front of the CGRA PE ALU. Holds the configured
//   instruction, gathers two operands from the N/E/S/W neighbour channels,
//   the sign-extended immediate, the PE's last accepted result or constant 0,
//   pulses the ALU for one cycle, captures the result and offers it on a
//   valid/ready channel.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  pe_operand_fetch_if.slave (config, neighbours, ALU, result, op_err)
//   Optional build macro PE_FETCH_STALL_CNT_EN adds bus.stall_cnt, a
//   saturating count of GATHER cycles that end with a slot still unfilled.
module pe_operand_fetch #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  pe_operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GATHER, EXEC, DRAIN} state_t;

  state_t           state, state_nx;
  logic [31:9]      instr;           // reserved bits [8:0] are not stored
  logic [WIDTH-1:0] opnd1, opnd2;
  logic             slot1_full, slot2_full;
  logic [WIDTH-1:0] last_res;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             op_err_r;

  logic [2:0]       src1, src2;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] src1_val, src2_val;
  logic             take1, take2, both_done;
  logic [3:0]       nb_ready;
  logic             alu_en;
  logic             unused_rsvd;

  assign unused_rsvd = ^bus.cfg_instr[8:0];

  assign src1    = instr[14:12];
  assign src2    = instr[11:9];
  assign imm_ext = {{(WIDTH-IMM_W){instr[31]}}, instr[31 -: IMM_W]};

  function automatic logic [WIDTH-1:0] pick(input logic [2:0]         sel,
                                            input logic [4*WIDTH-1:0] nb,
                                            input logic [WIDTH-1:0]   imm,
                                            input logic [WIDTH-1:0]   prev);
    case (sel)
      3'd0:    return nb[0*WIDTH +: WIDTH];
      3'd1:    return nb[1*WIDTH +: WIDTH];
      3'd2:    return nb[2*WIDTH +: WIDTH];
      3'd3:    return nb[3*WIDTH +: WIDTH];
      3'd4:    return imm;
      3'd5:    return prev;
      default: return '0;
    endcase
  endfunction

  assign src1_val = pick(src1, bus.nb_data, imm_ext, last_res);
  assign src2_val = pick(src2, bus.nb_data, imm_ext, last_res);

  // Handshake-free sources (sel[2]=1) fill on the first GATHER cycle; a
  // neighbour slot fills when its channel is valid, since ready is implied.
  // Two slots on the same channel both fill from the one token.
  always_comb begin
    state_nx  = state;
    nb_ready  = '0;
    take1     = 1'b0;
    take2     = 1'b0;
    both_done = 1'b0;
    alu_en    = 1'b0;
    if (state == GATHER) begin
      if (!slot1_full && !src1[2]) nb_ready[src1[1:0]] = 1'b1;
      if (!slot2_full && !src2[2]) nb_ready[src2[1:0]] = 1'b1;
      take1 = !slot1_full && (src1[2] || bus.nb_valid[src1[1:0]]);
      take2 = !slot2_full && (src2[2] || bus.nb_valid[src2[1:0]]);
      both_done = (slot1_full || take1) && (slot2_full || take2);
    end
    if (state == EXEC) alu_en = !instr[18];
    if (bus.cfg_we) begin
      state_nx = GATHER;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        GATHER:  if (both_done) state_nx = EXEC;
        EXEC:    state_nx = DRAIN;
        DRAIN:   if (bus.out_ready) state_nx = GATHER;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      opnd1       <= '0;
      opnd2       <= '0;
      slot1_full  <= 1'b0;
      slot2_full  <= 1'b0;
      last_res    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      op_err_r    <= 1'b0;
    end else if (bus.cfg_we) begin
      // Reconfiguration wins over any transfer or result in flight.
      instr       <= bus.cfg_instr[31:9];
      opnd1       <= '0;
      opnd2       <= '0;
      slot1_full  <= 1'b0;
      slot2_full  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        GATHER: begin
          if (take1) begin
            opnd1      <= src1_val;
            slot1_full <= 1'b1;
          end
          if (take2) begin
            opnd2      <= src2_val;
            slot2_full <= 1'b1;
          end
        end
        EXEC: begin
          out_valid_r <= 1'b1;
          if (instr[18]) begin
            out_data_r <= '0;
            op_err_r   <= 1'b1;
          end else begin
            out_data_r <= bus.alu_out;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            last_res    <= out_data_r;
            slot1_full  <= 1'b0;
            slot2_full  <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PE_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  always_ff @(posedge clk) begin
    if (rst || bus.cfg_we)
      stall_cnt_r <= '0;
    else if (state == GATHER && !both_done && stall_cnt_r != '1)
      stall_cnt_r <= stall_cnt_r + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt_r;
`endif

  assign bus.nb_ready  = nb_ready;
  assign bus.alu_in1   = opnd1;
  assign bus.alu_in2   = opnd2;
  assign bus.alu_en    = alu_en;
  assign bus.alu_op    = instr[18:15];
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.op_err    = op_err_r;

endmodule

// File: tb/tb_pe_operand_fetch.sv
// tb_pe_operand_fetch
//   Directed scenarios plus randomized operations for pe_operand_fetch.
//   Expected operands and results come from a transaction-level model:
//   each operation's operands are resolved from the source selectors, the
//   offered neighbour tokens, the immediate and the last accepted result.
module tb_pe_operand_fetch;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [WIDTH-1:0] tok [4];
  int               hs  [4];
  logic [WIDTH-1:0] last_m;
  logic [WIDTH-1:0] res_m;
  logic [31:0]      cur_instr;

  pe_operand_fetch_if #(.WIDTH(WIDTH)) bus ();

  pe_operand_fetch #(.WIDTH(WIDTH), .IMM_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return (a < b) ? a : b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);

  function automatic logic [31:0] src_val(input logic [2:0] sel, input logic [12:0] imm);
    if (sel < 3'd4) return tok[sel[1:0]];
    if (sel == 3'd4) return {{19{imm[12]}}, imm};
    if (sel == 3'd5) return last_m;
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [12:0] imm);
    cur_instr     = {imm, op, s1, s2, 9'($urandom)};
    bus.cfg_instr = cur_instr;
    bus.cfg_we    = 1'b1;
    tick;
    bus.cfg_we    = 1'b0;
  endtask

  // Gathers operands for cur_instr using tok[], checks the EXEC cycle and the
  // first DRAIN cycle, then holds the result for 'hold' extra cycles.
  task automatic run_op(input string tag, input int hold);
    logic [3:0]  op;
    logic [2:0]  s1, s2;
    logic [12:0] imm;
    logic [3:0]  need, pend;
    logic [31:0] e1, e2;
    int          cyc;
    op   = cur_instr[18:15];
    s1   = cur_instr[14:12];
    s2   = cur_instr[11:9];
    imm  = cur_instr[31:19];
    need = '0;
    if (!s1[2]) need[s1[1:0]] = 1'b1;
    if (!s2[2]) need[s2[1:0]] = 1'b1;
    pend = need;
    cyc  = 0;
    for (int k = 0; k < 4; k++) hs[k] = 0;
    e1 = src_val(s1, imm);
    e2 = src_val(s2, imm);
    do begin
      for (int k = 0; k < 4; k++) begin
        bus.nb_valid[k] = pend[k] && ($urandom_range(0, 2) != 0);
        bus.nb_data[k*WIDTH +: WIDTH] = pend[k] ? tok[k] : $urandom;
      end
      #1;
      chk({tag, "_ready_mask"}, 32'(bus.nb_ready & ~need), 0);
      for (int k = 0; k < 4; k++)
        if (bus.nb_valid[k] && bus.nb_ready[k]) begin
          pend[k] = 1'b0;
          hs[k]++;
        end
      tick;
      cyc++;
    end while (pend != '0 && cyc < 60);
    chk({tag, "_gather_done"}, 32'(pend), 0);
    bus.nb_valid = '0;
    #1;
    chk({tag, "_alu_en"}, 32'(bus.alu_en), 32'(!op[3]));
    chk({tag, "_in1"}, bus.alu_in1, e1);
    chk({tag, "_in2"}, bus.alu_in2, e2);
    chk({tag, "_op"}, 32'(bus.alu_op), 32'(op));
    chk({tag, "_exec_ready"}, 32'(bus.nb_ready), 0);
    res_m = op[3] ? 32'd0 : alu_fn(op, e1, e2);
    tick;
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_data"}, bus.out_data, res_m);
    chk({tag, "_en_pulse"}, 32'(bus.alu_en), 0);
    if (op[3]) chk({tag, "_op_err"}, 32'(bus.op_err), 1);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
      chk({tag, "_hold_data"}, bus.out_data, res_m);
    end
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    last_m = res_m;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_instr = '0;
    bus.nb_data   = '0;
    bus.nb_valid  = '0;
    bus.out_ready = 1'b0;
    last_m        = '0;
    res_m         = '0;
    cur_instr     = '0;
    rst           = 1'b1;
    repeat (3) tick;

    // reset state
    chk("rst_nb_ready", 32'(bus.nb_ready), 0);
    chk("rst_alu_en", 32'(bus.alu_en), 0);
    chk("rst_in1", bus.alu_in1, 0);
    chk("rst_in2", bus.alu_in2, 0);
    chk("rst_op", 32'(bus.alu_op), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_op_err", 32'(bus.op_err), 0);
    rst = 1'b0;
    tick;
    chk("idle_nb_ready", 32'(bus.nb_ready), 0);

    // 1: N + IMM(5), N sends 7 -> 12, held 3 cycles
    tok[0] = 32'd7;
    configure(4'd0, 3'd0, 3'd4, 13'd5);
    run_op("t1", 3);
    accept("t1");

    // 2: E - E, one token fills both slots
    tok[1] = 32'd9;
    configure(4'd1, 3'd1, 3'd1, 13'($urandom));
    run_op("t2", 1);
    chk("t2_handshakes", 32'(hs[1]), 1);
    accept("t2");

    // 3: REG + S accumulates 1,2,3
    configure(4'd0, 3'd5, 3'd2, 13'd0);
    for (int i = 0; i < 3; i++) begin
      tok[2] = 32'd1;
      run_op("t3", 0);
      accept("t3");
    end

    // 4: reconfigure while DRAIN holds 12
    tok[0] = 32'd7;
    configure(4'd0, 3'd0, 3'd4, 13'd5);
    run_op("t4", 1);
    configure(4'd2, 3'd0, 3'd1, 13'd0);
    chk("t4_valid_fall", 32'(bus.out_valid), 0);
    #1;
    chk("t4_new_op", 32'(bus.alu_op), 2);
    chk("t4_gather_ready", 32'(bus.nb_ready), 32'h3);
    tok[0] = $urandom;
    tok[1] = $urandom;
    run_op("t4b", 0);
    accept("t4b");

    // 5: unsupported op, N and W operands
    chk("t5_err_before", 32'(bus.op_err), 0);
    tok[0] = $urandom;
    tok[3] = $urandom;
    configure(4'b1010, 3'd0, 3'd3, 13'd0);
    run_op("t5", 1);
    accept("t5");
    configure(4'd0, 3'd4, 3'd4, 13'h21);
    run_op("t5b", 0);
    chk("t5_err_sticky", 32'(bus.op_err), 1);
    accept("t5b");

    // 6: reset during EXEC
    configure(4'd0, 3'd4, 3'd4, 13'h11);
    tick;
    #1;
    chk("t6_in_exec", 32'(bus.alu_en), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    last_m = '0;
    #1;
    chk("t6_nb_ready", 32'(bus.nb_ready), 0);
    chk("t6_alu_en", 32'(bus.alu_en), 0);
    chk("t6_in1", bus.alu_in1, 0);
    chk("t6_in2", bus.alu_in2, 0);
    chk("t6_op", 32'(bus.alu_op), 0);
    chk("t6_out_data", bus.out_data, 0);
    chk("t6_out_valid", 32'(bus.out_valid), 0);
    chk("t6_op_err", 32'(bus.op_err), 0);
    tick;
    chk("t6_idle_ready", 32'(bus.nb_ready), 0);
    configure(4'd0, 3'd5, 3'd4, 13'd3);
    run_op("t6b", 0);
    accept("t6b");

`ifdef PE_FETCH_STALL_CNT_EN
    configure(4'd0, 3'd0, 3'd4, 13'd1);
    repeat (20) tick;
    chk("stall_cnt", 32'(bus.stall_cnt), 20);
    tok[0] = $urandom;
    run_op("stall", 0);
    accept("stall");
`endif

    // reconfigure in GATHER after one slot was filled: that operand is dropped
    configure(4'd0, 3'd0, 3'd1, 13'd0);
    bus.nb_valid = 4'b0001;
    bus.nb_data[0 +: WIDTH] = 32'h1111;
    #1;
    chk("drop_ready_n", 32'(bus.nb_ready[0]), 1);
    tick;
    bus.nb_valid = '0;
    configure(4'd0, 3'd1, 3'd4, 13'd7);
    tok[1] = 32'h500;
    run_op("drop", 0);
    accept("drop");

    // randomized operations
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++) tok[k] = $urandom;
      if (n == 0 || $urandom_range(0, 1) == 1)
        configure(4'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 13'($urandom));
      run_op("rnd", $urandom_range(0, 2));
      accept("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
